// File: rtl/lobster_cache_refill.sv
// lobster_cache_refill: miss handler and fill engine for the lobster_cache
// data array. Takes one core read or invalidate request at a time, probes
// the cache, fetches from backing memory on a miss, fills the cache, then
// answers the core. A bounded wait on memory means a silent memory produces
// an error response instead of a hung core.
//
// Handshake rules (all channels): a transfer happens on a rising edge where
// both valid and ready are high. A producer holds valid and its payload
// stable until that edge. Here req_ready is high only in IDLE. mem_req_valid
// with mem_addr is held until mem_req_ready. mem_resp_valid has no ready: it
// is consumed only in MEM_WAIT and dropped in every other state.
module lobster_cache_refill #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_inv,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] cache_addr_out,
    input  logic [DATA_WIDTH-1:0] cache_data_out,
    input  logic                  cache_hit,
    output logic                  cache_we,
    output logic                  cache_inv,
    output logic [ADDR_WIDTH-1:0] cache_addr_in,
    output logic [DATA_WIDTH-1:0] cache_data_in,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_FILL     = 3'd4,
        S_INV      = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    // Last MEM_WAIT count before giving up; counter is 8 bits wide.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic [7:0]            tmo_cnt;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus Moore strobes from the current state.
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        cache_we      = 1'b0;
        cache_inv     = 1'b0;
        mem_req_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_inv ? S_INV : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = cache_hit ? S_RESP : S_MEM_REQ;
            end
            S_MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                // A response in the final counted cycle still wins.
                if (mem_resp_valid) begin
                    state_d = S_FILL;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_FILL: begin
                cache_we = 1'b1;
                state_d  = S_RESP;
            end
            S_INV: begin
                cache_inv = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction datapath: address, returned word, error flag, wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        data_q <= '0;
                        err_q  <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        data_q <= cache_data_out;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready) begin
                        tmo_cnt <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        data_q <= mem_resp_data;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // data_q stays cleared so the error response reads 0.
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One address register feeds lookup, fill/invalidate and memory ports.
    assign cache_addr_out = addr_q;
    assign cache_addr_in  = addr_q;
    assign mem_addr       = addr_q;
    assign cache_data_in  = data_q;
    assign resp_data      = data_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_lobster_cache_refill.sv
// Directed bench for lobster_cache_refill, built with TIMEOUT=4.
module tb_lobster_cache_refill;

    localparam int AW = 36;
    localparam int DW = 64;
    localparam int TMO = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_MEM_REQ  = 3'd2;
    localparam logic [2:0] ST_MEM_WAIT = 3'd3;
    localparam logic [2:0] ST_FILL     = 3'd4;
    localparam logic [2:0] ST_INV      = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_inv;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic [AW-1:0] cache_addr_out;
    logic [DW-1:0] cache_data_out;
    logic          cache_hit;
    logic          cache_we;
    logic          cache_inv;
    logic [AW-1:0] cache_addr_in;
    logic [DW-1:0] cache_data_in;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic [2:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int inv_cnt = 0;
    int both_cnt = 0;
    int unexp_cnt = 0;

    // Scoreboard entries are {resp_err, resp_data}.
    logic [DW:0] exp_q[$];

    lobster_cache_refill #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_inv       (req_inv),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .cache_addr_out(cache_addr_out),
        .cache_data_out(cache_data_out),
        .cache_hit     (cache_hit),
        .cache_we      (cache_we),
        .cache_inv     (cache_inv),
        .cache_addr_in (cache_addr_in),
        .cache_data_in (cache_data_in),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .dbg_state     (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in the first cycle after E0.
    task automatic issue(input logic [AW-1:0] addr, input logic inv);
        chk("accept_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_inv   = inv;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        req_inv   = 1'b0;
        req_addr  = $urandom_range(0, 255);
    endtask

    // Monitor: strobe counts and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (cache_we) we_cnt++;
        if (cache_inv) inv_cnt++;
        if (cache_we && cache_inv) both_cnt++;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                unexp_cnt++;
            end else begin
                chk("sb_resp", {resp_err, resp_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_inv        = 1'b0;
        req_addr       = '0;
        cache_hit      = 1'b0;
        cache_data_out = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        step();
        step();

        // Reset state
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_strobes", {resp_valid, resp_err, cache_we, cache_inv, mem_req_valid}, 5'b0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_data", resp_data, '0);
        rst = 1'b0;
        step();

        // Hit: resp_valid 2 cycles after accept, no memory request
        cache_hit      = 1'b1;
        cache_data_out = 64'h12345678;
        exp_q.push_back({1'b0, 64'h12345678});
        issue(36'hFFF80000, 1'b0);
        chk("hit_lookup", dbg_state, ST_LOOKUP);
        chk("hit_caddr", cache_addr_out, 36'hFFF80000);
        chk("hit_nomem1", mem_req_valid, 1'b0);
        step();
        chk("hit_resp_valid", resp_valid, 1'b1);
        chk("hit_resp_data", resp_data, 64'h12345678);
        chk("hit_nomem2", mem_req_valid, 1'b0);
        cache_hit      = 1'b0;
        cache_data_out = 64'h5555AAAA5555AAAA;
        step();
        chk("hit_idle", req_ready, 1'b1);

        // Miss with memory stalled 3 cycles, response 3 cycles into MEM_WAIT
        exp_q.push_back({1'b0, 64'hDEADBEEF});
        issue(36'hFFF80000, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", mem_req_valid, 1'b1);
            chk("stall_addr", mem_addr, 36'hFFF80000);
            step();
        end
        chk("hs_valid", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        step();
        for (int k = 1; k <= 2; k++) begin
            chk("miss_wait", dbg_state, ST_MEM_WAIT);
            chk("miss_wait_noreq", mem_req_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEADBEEF;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        chk("miss_fill_we", cache_we, 1'b1);
        chk("miss_fill_addr", cache_addr_in, 36'hFFF80000);
        chk("miss_fill_data", cache_data_in, 64'hDEADBEEF);
        step();
        chk("miss_resp", {resp_valid, resp_err, resp_data}, {2'b10, 64'hDEADBEEF});
        step();

        // Miss latency with ready tied high, response at MEM_WAIT k=2 -> 6 cycles
        exp_q.push_back({1'b0, 64'h0123456789ABCDEF});
        issue(36'h000ABCDE0, 1'b0);
        step();
        chk("lat_memreq", mem_req_valid, 1'b1);
        step();
        chk("lat_wait1", dbg_state, ST_MEM_WAIT);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0123456789ABCDEF;
        step();
        mem_resp_valid = 1'b0;
        chk("lat_fill", dbg_state, ST_FILL);
        chk("lat_noresp5", resp_valid, 1'b0);
        step();
        chk("lat_resp6", resp_valid, 1'b1);
        step();

        // Invalidate
        exp_q.push_back({1'b0, 64'h0});
        issue(36'h000001000, 1'b1);
        chk("inv_state", dbg_state, ST_INV);
        chk("inv_strobes", {cache_inv, cache_we}, 2'b10);
        chk("inv_addr", cache_addr_in, 36'h000001000);
        step();
        chk("inv_resp", {resp_valid, resp_err, resp_data}, {2'b10, 64'h0});
        chk("inv_once", cache_inv, 1'b0);
        step();

        // Timeout: exactly TMO cycles in MEM_WAIT, then error response
        exp_q.push_back({1'b1, 64'h0});
        issue(36'h00FF00000, 1'b0);
        step();
        step();
        for (int k = 1; k <= TMO; k++) begin
            chk("tmo_wait", dbg_state, ST_MEM_WAIT);
            step();
        end
        chk("tmo_resp", {resp_valid, resp_err, resp_data}, {2'b11, 64'h0});
        chk("tmo_nowe", cache_we, 1'b0);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hBADBADBAD;
        step();
        mem_resp_valid = 1'b0;
        chk("late_idle", dbg_state, ST_IDLE);
        chk("late_ready", req_ready, 1'b1);
        chk("late_quiet", {cache_we, resp_valid}, 2'b00);
        step();

        // Response in final MEM_WAIT cycle wins over the timeout
        exp_q.push_back({1'b0, 64'hCAFEF00D});
        issue(36'h012340000, 1'b0);
        step();
        step();
        for (int k = 1; k < TMO; k++) begin
            step();
        end
        chk("edge_last_wait", dbg_state, ST_MEM_WAIT);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hCAFEF00D;
        step();
        mem_resp_valid = 1'b0;
        chk("edge_fill", cache_we, 1'b1);
        step();
        chk("edge_resp", {resp_valid, resp_err, resp_data}, {2'b10, 64'hCAFEF00D});
        step();

        // Reset while in MEM_WAIT aborts at once
        issue(36'h077700000, 1'b0);
        step();
        step();
        step();
        chk("abort_wait", dbg_state, ST_MEM_WAIT);
        rst = 1'b1;
        #1;
        chk("abort_state", dbg_state, ST_IDLE);
        chk("abort_ready", req_ready, 1'b1);
        chk("abort_strobes", {resp_valid, resp_err, cache_we, cache_inv, mem_req_valid}, 5'b0);
        chk("abort_addr", mem_addr, '0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFEEDFACE;
        step();
        chk("abort_hold", {cache_we, resp_valid, dbg_state}, {2'b00, ST_IDLE});
        rst            = 1'b0;
        mem_resp_valid = 1'b0;
        step();
        step();
        chk("abort_after", {cache_we, resp_valid, req_ready}, 3'b001);
        step();

        // Final report
        chk("sb_drained", exp_q.size(), 0);
        chk("we_total", we_cnt, 3);
        chk("inv_total", inv_cnt, 1);
        chk("we_inv_overlap", both_cnt, 0);
        chk("resp_unexpected", unexp_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
